// File: rtl/painel_pkg.sv
// Shared types for the rotating display-panel register.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// modo_t   : operating mode as presented on the modo input.
// estado_t : scroll controller state.
package painel_pkg;

    // Encoding matches the two-bit modo input directly.
    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        LOAD  = 2'b01,
        ROT_E = 2'b10,   // rotate left, toward MSB
        ROT_D = 2'b11    // rotate right, toward LSB
    } modo_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } estado_t;

    // True for either rotate mode; bit 1 of the mode carries that meaning.
    function automatic logic is_rotacao(input modo_t m);
        return (m == ROT_E) || (m == ROT_D);
    endfunction

endpackage

// File: rtl/painel_rotativo_param_divisor_passo.sv
// Step-rate prescaler: emits one step every limit+1 enabled cycles.
// Latency: step is combinational from the count; the count updates on the next edge.
// Backpressure: en low freezes the count; clr forces it to zero and masks the step.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : count enable (scroller running with a rotate mode)
//   clr        : synchronous clear, takes priority over en
//   limit      : step period minus one
//   step       : high in the cycle whose edge performs a step
module divisor_passo #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] limit,
    output logic             step
);

    logic [DIV_W-1:0] count;

    // >= rather than == so that lowering limit below the current count
    // fires on the very next enabled cycle instead of wrapping the counter.
    assign step = en && !clr && (count >= limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (step) begin
            count <= '0;
        end else if (en) begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/painel_rotativo_param.sv
// Parametrised circular scroll register driving a WIN-bit display window.
// Latency: load and each step are visible on the outputs one cycle after the sampling edge.
// Backpressure: none; hold mode and run=0 freeze the datapath, load overrides everything.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   modo       : 00 hold, 01 load, 10 rotate left, 11 rotate right
//   dado       : parallel load value
//   passo_div  : step period minus one, in clk cycles
//   run        : scroll enable
//   one_shot   : stop after one full lap
//   reg_q      : full register contents
//   janela     : top WIN bits of reg_q
//   pos        : rotation offset since the last load, modulo WIDTH
//   volta      : one-cycle pulse when a step brings pos back to 0
//   ocupado    : high while scrolling (RUN state)
module painel_rotativo_param
    import painel_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int WIN   = 7,
    parameter int DIV_W = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               modo,
    input  logic [WIDTH-1:0]         dado,
    input  logic [DIV_W-1:0]         passo_div,
    input  logic                     run,
    input  logic                     one_shot,
    output logic [WIDTH-1:0]         reg_q,
    output logic [WIN-1:0]           janela,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     volta,
    output logic                     ocupado
);

    localparam int              PW      = $clog2(WIDTH);
    localparam logic [PW-1:0]   POS_MAX = PW'(WIDTH - 1);

    modo_t   modo_e;
    estado_t estado;

    logic             carga;
    logic             conta_en;
    logic             conta_clr;
    logic             passo;
    logic [WIDTH-1:0] reg_prox;
    logic [PW-1:0]    pos_prox;

    assign modo_e = modo_t'(modo);
    assign carga  = (modo_e == LOAD);

    // The prescaler only advances while actually scrolling. Outside RUN it
    // is held at zero so every entry into RUN starts a full step period;
    // inside RUN with hold mode it simply freezes and resumes later.
    assign conta_en  = (estado == RUN) && run && is_rotacao(modo_e);
    assign conta_clr = carga || (estado != RUN);

    divisor_passo #(
        .DIV_W (DIV_W)
    ) u_divisor_passo (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (conta_en),
        .clr   (conta_clr),
        .limit (passo_div),
        .step  (passo)
    );

    // Next register value and offset for a step in the current direction.
    // The offset wraps explicitly so non-power-of-two WIDTH stays correct.
    always_comb begin
        reg_prox = reg_q;
        pos_prox = pos;
        if (modo_e == ROT_E) begin
            reg_prox = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
            pos_prox = (pos == POS_MAX) ? '0 : pos + PW'(1);
        end else begin
            reg_prox = {reg_q[0], reg_q[WIDTH-1:1]};
            pos_prox = (pos == '0) ? POS_MAX : pos - PW'(1);
        end
    end

    // Scroll controller and datapath. ocupado and volta are kept as their own
    // flops so every output comes straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado  <= IDLE;
            reg_q   <= '0;
            pos     <= '0;
            volta   <= 1'b0;
            ocupado <= 1'b0;
        end else if (carga) begin
            // Load wins over any step or transition on the same edge.
            reg_q   <= dado;
            pos     <= '0;
            estado  <= IDLE;
            volta   <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            volta <= 1'b0;
            case (estado)
                IDLE: begin
                    if (run && is_rotacao(modo_e)) begin
                        estado  <= RUN;
                        ocupado <= 1'b1;
                    end
                end

                RUN: begin
                    if (!run) begin
                        estado  <= IDLE;
                        ocupado <= 1'b0;
                    end else if (passo) begin
                        reg_q <= reg_prox;
                        pos   <= pos_prox;
                        if (pos_prox == '0) begin
                            volta <= 1'b1;
                            // A completed lap in one-shot mode parks the
                            // register back on the loaded message.
                            if (one_shot) begin
                                estado  <= DONE;
                                ocupado <= 1'b0;
                            end
                        end
                    end
                end

                DONE: begin
                    if (!run) begin
                        estado <= IDLE;
                    end
                end

                default: begin
                    estado  <= IDLE;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign janela = reg_q[WIDTH-1 -: WIN];

endmodule

// File: tb/tb_painel_rotativo_param.sv
module tb_painel_rotativo_param;

    localparam int W   = 16;
    localparam int WIN = 7;
    localparam int DW  = 24;

    logic          clk;
    logic          rst_n;
    logic [1:0]    modo;
    logic [W-1:0]  dado;
    logic [DW-1:0] passo_div;
    logic          run;
    logic          one_shot;
    logic [W-1:0]  reg_q;
    logic [WIN-1:0] janela;
    logic [3:0]    pos;
    logic          volta;
    logic          ocupado;

    int n_cmp = 0;
    int n_err = 0;

    painel_rotativo_param #(.WIDTH(W), .WIN(WIN), .DIV_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .modo      (modo),
        .dado      (dado),
        .passo_div (passo_div),
        .run       (run),
        .one_shot  (one_shot),
        .reg_q     (reg_q),
        .janela    (janela),
        .pos       (pos),
        .volta     (volta),
        .ocupado   (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the register is described as the loaded message
    // rotated left by an offset; scroll status kept as plain flags.
    logic [W-1:0] m_msg;
    int           m_off;
    bit           m_running;
    bit           m_done;
    int           m_cnt;
    bit           m_volta;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int k);
        logic [2*W-1:0] t;
        t = {v, v} << k;
        return t[2*W-1:W];
    endfunction

    task automatic model_reset();
        m_msg = '0; m_off = 0; m_running = 0; m_done = 0; m_cnt = 0; m_volta = 0;
    endtask

    // Predicts the effect of the next rising edge from the current inputs.
    task automatic model_step();
        bit rot;
        rot = (modo == 2'b10) || (modo == 2'b11);
        m_volta = 0;
        if (modo == 2'b01) begin
            m_msg = dado; m_off = 0; m_running = 0; m_done = 0; m_cnt = 0;
        end else if (m_running) begin
            if (!run) begin
                m_running = 0; m_cnt = 0;
            end else if (rot) begin
                if (m_cnt >= int'(passo_div)) begin
                    m_cnt = 0;
                    if (modo == 2'b10) m_off = (m_off + 1) % W;
                    else               m_off = (m_off + W - 1) % W;
                    if (m_off == 0) begin
                        m_volta = 1;
                        if (one_shot) begin
                            m_running = 0; m_done = 1;
                        end
                    end
                end else begin
                    m_cnt++;
                end
            end
        end else if (m_done) begin
            if (!run) m_done = 0;
        end else begin
            if (run && rot) m_running = 1;
        end
    endtask

    task automatic tick();
        logic [W-1:0] exp_q;
        logic [WIN-1:0] exp_j;
        model_step();
        @(posedge clk);
        #1;
        exp_q = rotl(m_msg, m_off);
        exp_j = exp_q[W-1 -: WIN];
        chk("reg_q",   32'(reg_q),   32'(exp_q));
        chk("janela",  32'(janela),  32'(exp_j));
        chk("pos",     32'(pos),     32'(m_off));
        chk("volta",   32'(volta),   32'(m_volta));
        chk("ocupado", 32'(ocupado), 32'(m_running));
    endtask

    initial begin
        int vcount;
        int dir;
        rst_n = 1'b0; modo = 2'b00; dado = '0; passo_div = '0; run = 1'b0; one_shot = 1'b0;
        model_reset();
        #12;
        chk("rst_reg_q", 32'(reg_q), 0);
        chk("rst_pos", 32'(pos), 0);
        chk("rst_volta", 32'(volta), 0);
        chk("rst_ocupado", 32'(ocupado), 0);
        chk("rst_janela", 32'(janela), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Load
        modo = 2'b01; dado = 16'hA5C3;
        tick();
        chk("load_reg_q", 32'(reg_q), 32'hA5C3);
        chk("load_janela", 32'(janela), 32'b1010010);
        chk("load_pos", 32'(pos), 0);

        // Continuous left rotation, one step per cycle
        modo = 2'b10; run = 1'b1; passo_div = 0; one_shot = 1'b0;
        tick();
        tick();
        chk("left1_reg_q", 32'(reg_q), 32'h4B87);
        chk("left1_pos", 32'(pos), 1);
        vcount = 0;
        repeat (15) begin
            tick();
            vcount += int'(volta);
        end
        chk("left16_reg_q", 32'(reg_q), 32'hA5C3);
        chk("left16_pos", 32'(pos), 0);
        chk("left16_voltas", 32'(vcount), 1);
        chk("left16_ocupado", 32'(ocupado), 1);

        // Slow right rotation: one step every 4 cycles
        modo = 2'b11; passo_div = 3;
        repeat (3) tick();
        chk("right_wait_reg_q", 32'(reg_q), 32'hA5C3);
        tick();
        chk("right1_reg_q", 32'(reg_q), 32'hD2E1);
        chk("right1_pos", 32'(pos), 15);

        // Hold mid-count, then resume with the remaining count
        repeat (2) tick();
        modo = 2'b00;
        repeat (5) tick();
        chk("hold_reg_q", 32'(reg_q), 32'hD2E1);
        chk("hold_ocupado", 32'(ocupado), 1);
        modo = 2'b11;
        tick();
        chk("resume_wait_reg_q", 32'(reg_q), 32'hD2E1);
        tick();
        chk("resume_reg_q", 32'(reg_q), 32'hE970);
        chk("resume_pos", 32'(pos), 14);

        // Load during RUN
        modo = 2'b01; dado = 16'h0001;
        tick();
        chk("midload_reg_q", 32'(reg_q), 32'h0001);
        chk("midload_pos", 32'(pos), 0);
        chk("midload_ocupado", 32'(ocupado), 0);
        chk("midload_volta", 32'(volta), 0);

        // One-shot lap
        dado = 16'hA5C3;
        tick();
        modo = 2'b10; one_shot = 1'b1; passo_div = 0; run = 1'b1;
        tick();
        repeat (16) tick();
        chk("oneshot_ocupado", 32'(ocupado), 0);
        chk("oneshot_reg_q", 32'(reg_q), 32'hA5C3);
        chk("oneshot_volta", 32'(volta), 1);
        repeat (3) tick();
        chk("done_frozen_reg_q", 32'(reg_q), 32'hA5C3);
        chk("done_frozen_ocupado", 32'(ocupado), 0);
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        chk("restart_ocupado", 32'(ocupado), 1);
        one_shot = 1'b0;
        repeat (5) tick();

        // Asynchronous reset in the middle of a cycle
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_reg_q", 32'(reg_q), 0);
        chk("arst_pos", 32'(pos), 0);
        chk("arst_volta", 32'(volta), 0);
        chk("arst_ocupado", 32'(ocupado), 0);
        model_reset();
        modo = 2'b00; run = 1'b0;
        @(posedge clk); #1;
        chk("arst_hold_reg_q", 32'(reg_q), 0);
        rst_n = 1'b1;

        // Randomized run with segment-wise direction bias
        dir = 2;
        for (int i = 0; i < 3000; i++) begin
            int r;
            if (i % 40 == 0) dir = $urandom_range(2, 3);
            r = $urandom_range(0, 99);
            if (r < 3)       modo = 2'b01;
            else if (r < 12) modo = 2'b00;
            else if (r < 20) modo = 2'($urandom_range(2, 3));
            else             modo = 2'(dir);
            dado = W'($urandom);
            run = ($urandom_range(0, 99) < 92);
            if ($urandom_range(0, 99) < 3) one_shot = ~one_shot;
            if ($urandom_range(0, 99) < 5) passo_div = DW'($urandom_range(0, 4));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
